// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one single-port RAM between a writer and a reader. The RAM window
// [LDATA, HDATA] is used as a circular buffer. A write pointer and a read
// pointer each wrap inside the window. A registered level counter tracks
// occupancy.
// Grants are combinational. When both requesters are eligible in the same
// cycle, the grant alternates, and the write side wins the first such cycle
// after reset.
//
// Ports
//   iClk       clock; all state changes on the rising edge
//   iClrn      asynchronous active-low reset
//   iWrReq     writer requests one write this cycle
//   iWrData    write data, valid with iWrReq
//   iRdReq     reader requests one read this cycle
//   oWrGnt     write accepted this cycle
//   oRdGnt     read accepted this cycle
//   oRamAddr   RAM address: write pointer on a write grant, read pointer otherwise
//   oRamWe     RAM write enable (equals oWrGnt)
//   oRamWData  RAM write data (equals iWrData)
//   oRdValid   RAM read data valid, one clock after oRdGnt
//   oFull      buffer holds DEPTH entries
//   oEmpty     buffer holds no entries
//   oLevel     current occupancy
module ram_port_arbiter #(
  parameter int unsigned ADDRWIDTH = 11,
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned LDATA     = 18 * 55 + 1,
  parameter int unsigned HDATA     = 18 * 66
) (
  input  logic                 iClk,
  input  logic                 iClrn,
  input  logic                 iWrReq,
  input  logic [DWIDTH-1:0]    iWrData,
  input  logic                 iRdReq,
  output logic                 oWrGnt,
  output logic                 oRdGnt,
  output logic [ADDRWIDTH-1:0] oRamAddr,
  output logic                 oRamWe,
  output logic [DWIDTH-1:0]    oRamWData,
  output logic                 oRdValid,
  output logic                 oFull,
  output logic                 oEmpty,
  output logic [ADDRWIDTH-1:0] oLevel
);

  localparam logic [ADDRWIDTH-1:0] LoAddr = ADDRWIDTH'(LDATA);
  localparam logic [ADDRWIDTH-1:0] HiAddr = ADDRWIDTH'(HDATA);
  localparam logic [ADDRWIDTH-1:0] Depth  = ADDRWIDTH'(HDATA - LDATA + 1);
  localparam logic [ADDRWIDTH-1:0] One    = ADDRWIDTH'(1);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e                 stateQ, stateD;
  logic [ADDRWIDTH-1:0]   wrPtrQ, wrPtrD;
  logic [ADDRWIDTH-1:0]   rdPtrQ, rdPtrD;
  logic [ADDRWIDTH-1:0]   levelQ, levelD;
  logic                   rdValidQ;
  // Winner of the most recent contended cycle: 1 = write, 0 = read.
  // It resets to 0 so that the write side wins the first contention.
  logic                   lastWrQ, lastWrD;
  logic                   wrElig, rdElig;
  logic                   wrGnt, rdGnt;
  logic                   full, empty;

  assign full  = (levelQ == Depth);
  assign empty = (levelQ == '0);

  always_ff @(posedge iClk or negedge iClrn) begin
    if (!iClrn) begin
      stateQ   <= StInit;
      wrPtrQ   <= LoAddr;
      rdPtrQ   <= LoAddr;
      levelQ   <= '0;
      rdValidQ <= 1'b0;
      lastWrQ  <= 1'b0;
    end else begin
      stateQ   <= stateD;
      wrPtrQ   <= wrPtrD;
      rdPtrQ   <= rdPtrD;
      levelQ   <= levelD;
      rdValidQ <= rdGnt;
      lastWrQ  <= lastWrD;
    end
  end

  always_comb begin
    // INIT lasts exactly one clock; RUN is held until reset.
    stateD  = StRun;
    wrPtrD  = wrPtrQ;
    rdPtrD  = rdPtrQ;
    levelD  = levelQ;
    lastWrD = lastWrQ;

    wrElig = (stateQ == StRun) && iWrReq && !full;
    rdElig = (stateQ == StRun) && iRdReq && !empty;

    // Under contention, the side that lost last time wins now.
    wrGnt = wrElig && (!rdElig || !lastWrQ);
    rdGnt = rdElig && (!wrElig || lastWrQ);

    if (wrElig && rdElig) begin
      lastWrD = wrGnt;
    end

    if (stateQ == StInit) begin
      wrPtrD = LoAddr;
      rdPtrD = LoAddr;
    end else begin
      if (wrGnt) begin
        wrPtrD = (wrPtrQ == HiAddr) ? LoAddr : wrPtrQ + One;
        levelD = levelQ + One;
      end
      if (rdGnt) begin
        rdPtrD = (rdPtrQ == HiAddr) ? LoAddr : rdPtrQ + One;
        levelD = levelQ - One;
      end
    end
  end

  assign oWrGnt    = wrGnt;
  assign oRdGnt    = rdGnt;
  assign oRamWe    = wrGnt;
  assign oRamAddr  = wrGnt ? wrPtrQ : rdPtrQ;
  assign oRamWData = iWrData;
  assign oRdValid  = rdValidQ;
  assign oFull     = full;
  assign oEmpty    = empty;
  assign oLevel    = levelQ;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter. A reference model predicts grants, level and
// flags. Write addresses are queued as writes are granted. On each read grant
// the expected read address is taken from the head of that queue.
module tb_ram_port_arbiter;

  localparam int unsigned AW    = 11;
  localparam int unsigned DW    = 8;
  localparam int unsigned LO    = 991;
  localparam int unsigned HI    = 1188;
  localparam int unsigned DEPTH = HI - LO + 1;

  logic          iClk;
  logic          iClrn;
  logic          iWrReq;
  logic [DW-1:0] iWrData;
  logic          iRdReq;
  logic          oWrGnt;
  logic          oRdGnt;
  logic [AW-1:0] oRamAddr;
  logic          oRamWe;
  logic [DW-1:0] oRamWData;
  logic          oRdValid;
  logic          oFull;
  logic          oEmpty;
  logic [AW-1:0] oLevel;

  ram_port_arbiter #(
    .ADDRWIDTH(AW),
    .DWIDTH   (DW),
    .LDATA    (LO),
    .HDATA    (HI)
  ) dut (
    .iClk     (iClk),
    .iClrn    (iClrn),
    .iWrReq   (iWrReq),
    .iWrData  (iWrData),
    .iRdReq   (iRdReq),
    .oWrGnt   (oWrGnt),
    .oRdGnt   (oRdGnt),
    .oRamAddr (oRamAddr),
    .oRamWe   (oRamWe),
    .oRamWData(oRamWData),
    .oRdValid (oRdValid),
    .oFull    (oFull),
    .oEmpty   (oEmpty),
    .oLevel   (oLevel)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit mRun;
  int mWrPtr;
  int mLevel;
  bit mLastWr;
  bit mRdValid;
  int addrQ[$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Asserts reset just after a rising edge and checks the immediate effect,
  // then releases it well before the next edge.
  task automatic doReset();
    iClrn  = 1'b0;
    iWrReq = 1'b1;
    iRdReq = 1'b1;
    #1;
    checkVal("rst_rdvalid", 32'(oRdValid), 32'd0);
    checkVal("rst_level",   32'(oLevel),   32'd0);
    checkVal("rst_empty",   32'(oEmpty),   32'd1);
    checkVal("rst_full",    32'(oFull),    32'd0);
    checkVal("rst_wrgnt",   32'(oWrGnt),   32'd0);
    checkVal("rst_rdgnt",   32'(oRdGnt),   32'd0);
    #2;
    iClrn    = 1'b1;
    mRun     = 1'b0;
    mWrPtr   = LO;
    mLevel   = 0;
    mLastWr  = 1'b0;
    mRdValid = 1'b0;
    addrQ.delete();
  endtask

  // Runs one clock cycle. It is entered shortly after a rising edge, checks
  // the outputs at the falling edge and advances the model at the next
  // rising edge.
  task automatic cycle(input bit wr, input bit rd);
    bit expWr;
    bit expRd;
    int expAddr;
    iWrReq  = wr;
    iRdReq  = rd;
    iWrData = DW'($urandom);
    expWr = mRun && wr && (mLevel != DEPTH);
    expRd = mRun && rd && (mLevel != 0);
    if (expWr && expRd) begin
      if (mLastWr) expWr = 1'b0;
      else         expRd = 1'b0;
      mLastWr = expWr;
    end
    @(negedge iClk);
    checkVal("wrgnt",   32'(oWrGnt),   32'(expWr));
    checkVal("rdgnt",   32'(oRdGnt),   32'(expRd));
    checkVal("we",      32'(oRamWe),   32'(expWr));
    checkVal("rdvalid", 32'(oRdValid), 32'(mRdValid));
    checkVal("level",   32'(oLevel),   32'(mLevel));
    checkVal("full",    32'(oFull),    32'(mLevel == DEPTH));
    checkVal("empty",   32'(oEmpty),   32'(mLevel == 0));
    checkVal("wdata",   32'(oRamWData), 32'(iWrData));
    if (expWr) begin
      checkVal("wr_addr", 32'(oRamAddr), 32'(mWrPtr));
      addrQ.push_back(mWrPtr);
    end else if (expRd) begin
      if (addrQ.size() == 0) begin
        checkVal("rd_sb_empty", 32'd1, 32'd0);
      end else begin
        expAddr = addrQ.pop_front();
        checkVal("rd_addr", 32'(oRamAddr), 32'(expAddr));
      end
    end
    @(posedge iClk);
    mRun     = 1'b1;
    mRdValid = expRd;
    if (expWr) begin
      mWrPtr = (mWrPtr == HI) ? LO : mWrPtr + 1;
      mLevel++;
    end
    if (expRd) mLevel--;
    #1;
  endtask

  initial begin
    iClrn   = 1'b0;
    iWrReq  = 1'b0;
    iRdReq  = 1'b0;
    iWrData = '0;
    repeat (2) @(posedge iClk);
    #1;

    // Write requested from release: INIT cycle without a grant, then 991.
    doReset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    checkVal("first_level", 32'(oLevel), 32'd1);
    // Two more writes, then three reads and an idle cycle for the last oRdValid.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    checkVal("drain_empty", 32'(oEmpty), 32'd1);

    // A read while empty is ignored.
    repeat (3) cycle(1'b0, 1'b1);

    // Contention from level 1: expected grants W,R,W,R.
    cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Fill to full, attempt a write while full, then read once and wrap.
    doReset();
    cycle(1'b0, 1'b0);
    repeat (DEPTH) cycle(1'b1, 1'b0);
    checkVal("full_flag", 32'(oFull), 32'd1);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the cycle after a read grant discards the pending valid.
    while (mLevel == 0) cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    doReset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDRWIDTH, default 11: width of RAM address and level.
REQ-002 The block SHALL have parameter DWIDTH, default 8: data width.
REQ-003 The block SHALL have parameter LDATA, default 18*55+1 (991): lowest window address.
REQ-004 The block SHALL have parameter HDATA, default 18*66 (1188): highest window address; DEPTH = HDATA-LDATA+1 (198).
REQ-005 The block SHALL have port iClk, input, 1 bit: clock; all state on rising edge.
REQ-006 The block SHALL have port iClrn, input, 1 bit: reset, asynchronous, active-low.
REQ-007 The block SHALL have port iWrReq, input, 1 bit: writer requests one write this cycle.
REQ-008 The block SHALL have port iWrData, input, DWIDTH bits: write data, valid with iWrReq.
REQ-009 The block SHALL have port iRdReq, input, 1 bit: reader requests one read this cycle.
REQ-010 The block SHALL have port oWrGnt, output, 1 bit: write accepted this cycle.
REQ-011 The block SHALL have port oRdGnt, output, 1 bit: read accepted this cycle.
REQ-012 The block SHALL have port oRamAddr, output, ADDRWIDTH bits: single-port RAM address.
REQ-013 The block SHALL have port oRamWe, output, 1 bit: RAM write enable.
REQ-014 The block SHALL have port oRamWData, output, DWIDTH bits: RAM write data (= iWrData).
REQ-015 The block SHALL have port oRdValid, output, 1 bit: RAM read data valid (RAM latency 1).
REQ-016 The block SHALL have ports oFull, oEmpty (1 bit each) and oLevel (ADDRWIDTH bits): occupancy.

Function
REQ-017 The state machine SHALL have states INIT and RUN; INIT -> RUN unconditionally after one clock; RUN held until reset.
REQ-018 In INIT, oWrGnt and oRdGnt SHALL be 0 regardless of requests; write and read pointers SHALL load LDATA.
REQ-019 In RUN, write is eligible when iWrReq=1 and oFull=0; read is eligible when iRdReq=1 and oEmpty=0.
REQ-020 With exactly one eligible requester, that requester SHALL be granted in the same cycle (combinational grant).
REQ-021 With both eligible, the grant SHALL go to the requester not granted on the most recent contended cycle; write wins first after reset.
REQ-022 oWrGnt and oRdGnt SHALL never be 1 in the same cycle.
REQ-023 oRamWe SHALL equal oWrGnt; oRamAddr SHALL be the write pointer on oWrGnt, the read pointer otherwise.
REQ-024 Each pointer SHALL advance by 1 on its grant and wrap from HDATA to LDATA; pointers never leave [LDATA, HDATA].
REQ-025 oLevel SHALL increment on oWrGnt and decrement on oRdGnt, registered; oFull = (oLevel == DEPTH), oEmpty = (oLevel == 0).
REQ-026 oRdValid SHALL be oRdGnt delayed by exactly one clock.
REQ-027 A write request while full, or a read request while empty, SHALL be ignored with no pointer or level change.

Reset
REQ-028 Asserting iClrn=0 SHALL immediately force state INIT, pointers LDATA, oLevel 0, oEmpty 1, oFull 0, oRdValid 0, contention flag to write-first.
REQ-029 Reset mid-operation SHALL discard a pending oRdValid and all buffered occupancy; first grant possible on second rising edge after release.

Verification
REQ-030 Release reset with iWrReq=1: cycle 1 no grant (INIT); cycle 2 oWrGnt=1, oRamAddr=991, oRamWe=1; oLevel=1 after.
REQ-031 Three writes then three reads: write addresses 991,992,993; read addresses 991,992,993; oRdValid one cycle after each oRdGnt; final oLevel=0, oEmpty=1.
REQ-032 Level 1, iWrReq=iRdReq=1 held for 4 cycles: grants W,R,W,R; oLevel alternates 2,1,2,1.
REQ-033 198 writes: last address 1188, oFull=1; 199th write not granted; one read (991) then one write uses address 991 (wrap).
REQ-034 Read request while empty after reset: no oRdGnt, no oRdValid, oLevel stays 0.
REQ-035 Assert iClrn=0 in the cycle after a read grant: oRdValid=0 immediately, oLevel=0, next write after release at 991.
